// File: rtl/mii_rx_frame_ctrl.sv
// MII receive frame controller: hunts preamble/SFD, delimits frames by idle
// timeout, buffers payload in a first-word-fall-through FIFO tagged with an
// end-of-frame marker, and reports each frame as good, runt, too long or
// overflow.
module mii_rx_frame_ctrl #(
  parameter int MAX_LEN      = 1518,
  parameter int MIN_LEN      = 64,
  parameter int PRE_MIN      = 2,
  parameter int IDLE_TIMEOUT = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        mii_clk,
  input  logic        reset,
  input  logic        in_rdy,
  input  logic [7:0]  in_q,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int PW = $clog2(PRE_MIN + 1) + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRE     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_RUNT = 2'd1;
  localparam logic [1:0] ERR_LONG = 2'd2;
  localparam logic [1:0] ERR_OVFL = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic          stage_valid_q, stage_valid_d;
  logic [7:0]    stage_data_q, stage_data_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   byte_count_q, byte_count_d;

  logic [8:0]    mem_q [FIFO_DEPTH];

  logic          timeout;
  logic          pop;
  logic          push_en;
  logic          push_last;
  logic [7:0]    push_data;
  logic          leaves_one;
  logic          sfd_room;

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign out_last   = out_valid ? mem_q[rd_ptr_q][8]   : 1'b0;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign byte_count = byte_count_q;

  assign pop        = out_valid && out_ready;
  // The timeout is the single cycle in which the idle counter arrives at its limit.
  assign timeout    = !in_rdy && (idle_cnt_q == IW'(IDLE_TIMEOUT - 1));
  // A push that leaves one free slot (after this cycle's pop) must close the frame.
  assign leaves_one = ((count_q + CW'(1) - (pop ? CW'(1) : CW'(0))) == CW'(FIFO_DEPTH - 1));
  assign sfd_room   = (count_q <= CW'(FIFO_DEPTH - 2));

  // Idle counter: cleared by every byte strobe, otherwise counts up and saturates.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (in_rdy) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IW'(IDLE_TIMEOUT)) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  // Frame FSM: preamble hunt, payload staging with one byte held back, and end classification.
  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    push_en       = 1'b0;
    push_last     = 1'b0;
    push_data     = stage_data_q;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    byte_count_d  = byte_count_q;

    case (state_q)
      S_IDLE: begin
        if (in_rdy && (in_q == 8'h55)) begin
          state_d   = S_PRE;
          pre_cnt_d = PW'(1);
        end
      end

      S_PRE: begin
        if (in_rdy) begin
          if (in_q == 8'h55) begin
            if (pre_cnt_q < PW'(PRE_MIN)) begin
              pre_cnt_d = pre_cnt_q + PW'(1);
            end
          end else if ((in_q == 8'hD5) && (pre_cnt_q >= PW'(PRE_MIN))) begin
            if (sfd_room) begin
              state_d       = S_PAYLOAD;
              byte_cnt_d    = '0;
              stage_valid_d = 1'b0;
            end else begin
              state_d      = S_DROP;
              frame_err_d  = 1'b1;
              err_code_d   = ERR_OVFL;
              byte_count_d = '0;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end

      S_PAYLOAD: begin
        if (in_rdy) begin
          if (byte_cnt_q == 16'(MAX_LEN)) begin
            push_en       = stage_valid_q;
            push_last     = 1'b1;
            stage_valid_d = 1'b0;
            state_d       = S_DROP;
            frame_err_d   = 1'b1;
            err_code_d    = ERR_LONG;
            byte_count_d  = 16'(MAX_LEN);
          end else begin
            byte_cnt_d    = byte_cnt_q + 16'd1;
            stage_data_d  = in_q;
            stage_valid_d = 1'b1;
            if (stage_valid_q) begin
              push_en = 1'b1;
              // On overflow the incoming byte is discarded, so the reported
              // count is what has actually been buffered for this frame.
              if (leaves_one) begin
                push_last     = 1'b1;
                stage_valid_d = 1'b0;
                byte_cnt_d    = byte_cnt_q;
                state_d       = S_DROP;
                frame_err_d   = 1'b1;
                err_code_d    = ERR_OVFL;
                byte_count_d  = byte_cnt_q;
              end
            end
          end
        end else if (timeout) begin
          push_en       = stage_valid_q;
          push_last     = 1'b1;
          stage_valid_d = 1'b0;
          state_d       = S_IDLE;
          byte_count_d  = byte_cnt_q;
          if (stage_valid_q && (byte_cnt_q >= 16'(MIN_LEN))) begin
            frame_ok_d = 1'b1;
            err_code_d = ERR_NONE;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_RUNT;
          end
        end
      end

      default: begin
        if (timeout) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // FIFO pointer and occupancy update; push and pop may coincide at any level.
  always_comb begin
    wr_ptr_d = push_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, counters, staging register, FIFO pointers and status outputs.
  always_ff @(posedge mii_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idle_cnt_q    <= '0;
      pre_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= '0;
      byte_count_q  <= '0;
    end else begin
      assert (!(push_en && (count_q == CW'(FIFO_DEPTH))));
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      pre_cnt_q     <= pre_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      byte_count_q  <= byte_count_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the outputs.
  always_ff @(posedge mii_clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= {push_last, push_data};
    end
  end

endmodule
